// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: single-cycle OR/MOV, sequential
// signed shift-add multiply that stalls the upstream pipeline until the product is ready.
module ex_stage #(
    parameter int MUL_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] oprand1_i,
    input  logic [31:0] oprand2_i,
    input  logic [4:0]  ALUop_i,
    input  logic [4:0]  writeAddr_i,
    input  logic        writeEnable_i,
    input  logic [1:0]  writeHILO_i,
    output logic [4:0]  exWriteAddr_o,
    output logic        exWriteEnable_o,
    output logic [1:0]  exWriteHILO_o,
    output logic [31:0] exWriteHI_data_o,
    output logic [31:0] exWriteLO_data_o,
    output logic [4:0]  writeAddr_o,
    output logic        writeEnable_o,
    output logic [1:0]  writeHILO_o,
    output logic [31:0] writeHI_data_o,
    output logic [31:0] writeLO_data_o,
    output logic        stall_o
);

    // state | meaning
    // IDLE  | no multiply in flight; single-cycle ops execute here
    // BUSY  | one shift-add iteration per cycle, upstream frozen
    // DONE  | signed product on bypass, stall released, back to IDLE

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_MOV  = 5'd2;
    localparam logic [4:0] ALU_MULT = 5'd3;
    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;

    logic [4:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  hilo_q, hilo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] mag1, mag2;
    logic [63:0] product;
    logic [31:0] res_hi, res_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            hilo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            hilo_q   <= hilo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // |0x80000000| wraps to 0x80000000, which is correct when read as unsigned
    assign mag1 = oprand1_i[31] ? (~oprand1_i + 32'd1) : oprand1_i;
    assign mag2 = oprand2_i[31] ? (~oprand2_i + 32'd1) : oprand2_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && ALUop_i == ALU_MULT) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {32'd0, mag1};
                    mplier_d = mag2;
                    neg_d    = oprand1_i[31] ^ oprand2_i[31];
                end
            end
            BUSY: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = (ALUop_i == ALU_MULT) && !flush_i;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase

        res_hi = '0;
        res_lo = '0;
        case (ALUop_i)
            ALU_OR:   res_lo = oprand1_i | oprand2_i;
            ALU_MOV: begin
                res_hi = oprand1_i;
                res_lo = oprand1_i;
            end
            ALU_MULT: begin
                res_hi = product[63:32];
                res_lo = product[31:0];
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase

        exWriteAddr_o    = writeAddr_i;
        exWriteEnable_o  = writeEnable_i && !stall_o;
        exWriteHILO_o    = stall_o ? 2'b00 : writeHILO_i;
        exWriteHI_data_o = res_hi;
        exWriteLO_data_o = res_lo;

        if (stall_o || flush_i) begin
            addr_d = '0;
            we_d   = 1'b0;
            hilo_d = '0;
            hi_d   = '0;
            lo_d   = '0;
        end else begin
            addr_d = exWriteAddr_o;
            we_d   = exWriteEnable_o;
            hilo_d = exWriteHILO_o;
            hi_d   = exWriteHI_data_o;
            lo_d   = exWriteLO_data_o;
        end
    end

    assign writeAddr_o    = addr_q;
    assign writeEnable_o  = we_q;
    assign writeHILO_o    = hilo_q;
    assign writeHI_data_o = hi_q;
    assign writeLO_data_o = lo_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register, directly downstream of instruction decode. Consumes decoded operands, ALU opcode and write-back controls from the ID/EX register. Computes GPR and HI/LO results: single-cycle for OR/MOV, 32-iteration sequential signed multiply for MULT. Drives combinational bypass results back to decode, registered results to MEM, and a stall request that freezes the upstream pipeline during a multiply.

## Interface
- `MUL_ITER`, default 32: multiply iteration count (one bit per cycle); fixed at 32 for this design.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low (0 = reset).
- `flush_i` in 1: synchronous flush; kills the current instruction.
- `oprand1_i`, `oprand2_i` in 32: operands from decode.
- `ALUop_i` in 5: shared-defines opcodes `ALU_NOP`, `ALU_OR`, `ALU_MOV`, `ALU_MULT`.
- `writeAddr_i` in 5, `writeEnable_i` in 1: GPR write-back control.
- `writeHILO_i` in 2: HI/LO write enables, [1]=HI, [0]=LO.
- `exWriteAddr_o` out 5, `exWriteEnable_o` out 1, `exWriteHILO_o` out 2, `exWriteHI_data_o` out 32, `exWriteLO_data_o` out 32: combinational bypass to decode.
- `writeAddr_o` out 5, `writeEnable_o` out 1, `writeHILO_o` out 2, `writeHI_data_o` out 32, `writeLO_data_o` out 32: registered EX/MEM outputs.
- `stall_o` out 1: combinational; holds PC, IF/ID and ID/EX registers.

## Operation
- GPR result travels on the LO data bus.
- `ALU_OR`: LO = op1 | op2; HI = 0.
- `ALU_MOV`: HI = LO = op1.
- `ALU_NOP` and unknown codes: HI = LO = 0; write enables passed through unchanged.
- `ALU_MULT`: signed 32x32 -> 64. HI = product[63:32], LO = product[31:0].
- Multiplier algorithm: magnitudes of both operands (|0x80000000| = 0x80000000 as unsigned), 32 shift-add iterations on a 64-bit accumulator, two's-complement negate when the operand signs differ.
- Multiply FSM states: IDLE, BUSY, DONE.
  - IDLE, `ALU_MULT` present, no flush: latch magnitudes and sign, counter = 0, go to BUSY; `stall_o` = 1.
  - BUSY: one iteration per cycle, counter++; `stall_o` = 1. Go to DONE after iteration 31 (counter == 31).
  - DONE: `stall_o` = 0; final signed product on bypass outputs; go to IDLE. The instruction is still present in this state and must not restart.
- Bypass outputs:
  - Never stalled: reflect the computed result and input controls.
  - While `stall_o` = 1: all write enables (`exWriteEnable_o`, `exWriteHILO_o`) forced to 0; data don't-care.
- EX/MEM register, each edge:
  - `stall_o` = 1 or `flush_i` = 1: load a bubble (enables 0, address 0, data 0).
  - Otherwise: load the bypass values.
- `flush_i` in any state: FSM to IDLE, counter cleared, bubble loaded. Flush has priority over every other transition.

## Timing
- Reset (`rst` = 0, async): all registered outputs 0, FSM IDLE, counter 0, accumulator 0. `stall_o` follows the combinational rule immediately.
- OR/MOV: result on bypass the same cycle; on registered outputs after 1 edge; no stall.
- MULT presented at cycle 0:
  - `stall_o` high in cycles 0..32 (33 cycles).
  - Cycle 33 is DONE: bypass valid, `stall_o` low.
  - Registered outputs carry the product after the edge ending cycle 33.
  - Next instruction enters at cycle 34.
- Back-to-back MULT: after DONE the FSM goes to IDLE, then restarts on the new instruction. No dead cycle beyond the normal 33-cycle stall.
- Reset deasserted mid-multiply is not a case: reset always returns to IDLE, and the held MULT restarts from iteration 0.

## Test plan
- Reset: assert `rst` = 0 mid-BUSY -> all registered outputs 0, `stall_o` = 0 with `ALU_NOP` input; after release a held MULT restarts with a full 33-cycle stall.
- OR: op1 = 0x0000F0F0, op2 = 0x00000F0F, writeAddr 5, enable 1 -> `exWriteLO_data_o` = 0x0000FFFF in the same cycle; registered `writeLO_data_o` = 0x0000FFFF and `writeAddr_o` = 5 after 1 edge; `stall_o` never high.
- MULT 0xFFFFFFFF x 0x00000002, `writeHILO_i` = 11 -> `stall_o` high exactly 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, `writeHILO_o` = 11; bubbles (`writeHILO_o` = 00) during the stall.
- MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0x00000000. MULT 0x7FFFFFFF x 0x7FFFFFFF -> HI = 0x3FFFFFFF, LO = 0x00000001.
- Flush at BUSY cycle 10 -> next edge loads a bubble, FSM IDLE. With MULT still on the input, a fresh 33-cycle stall follows and ends in the correct product.
- MOV with op1 = 0x12345678 immediately after a MULT -> HI = LO = 0x12345678 registered one edge after MULT's result; no extra stall.
